// File: rtl/trng_seq_ctrl.sv
// trng_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for the dual-ring TRNG core. It walks the core through
// reset, optional calibration and run phases. Random words are harvested into
// a small circular FIFO. A repetition-count health test runs on every
// harvested word.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   start          one-cycle pulse, begins the bring-up sequence from IDLE
//   stop           one-cycle pulse, aborts to IDLE from any state (beats start)
//   err_clr        clears the sticky health error (a same-cycle failure wins)
//   calib_cycles   calibration length in cycles, latched when start is accepted
//   trng_rst       core reset (IDLE and RST)
//   trng_en        core enable (CALIB, RUN, ACK)
//   trng_calib     core calibration request (CALIB)
//   trng_read      core read acknowledge, one cycle after each capture
//   trng_ready     core word-valid flag
//   trng_random    core word
//   pop            consume the FIFO head (ignored when empty)
//   pop_data       FIFO head, 0 when empty
//   fifo_count     words held, 0..DEPTH
//   busy           controller is not in IDLE
//   health_err     sticky repetition-test failure
//
// Core handshake: a word is taken when trng_ready is high in RUN and the FIFO
// has room. trng_read pulses in the following cycle. The controller then waits
// in ACK until trng_ready drops, so that one presented word is never taken
// twice.
// ----------------------------------------------------------------------------
module trng_seq_ctrl #(
  parameter int DEPTH      = 4,
  parameter int RST_CYCLES = 4,
  parameter int REP_LIMIT  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       err_clr,
  input  logic [31:0]                calib_cycles,
  output logic                       trng_rst,
  output logic                       trng_en,
  output logic                       trng_calib,
  output logic                       trng_read,
  input  logic                       trng_ready,
  input  logic [31:0]                trng_random,
  input  logic                       pop,
  output logic [31:0]                pop_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy,
  output logic                       health_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int NW = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_CALIB = 3'd2,
    S_RUN   = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [31:0]     cal_cnt;
  logic [RW-1:0]   rst_cnt;
  logic [31:0]     last_word;
  logic [NW-1:0]   rep_cnt;
  logic [NW-1:0]   rep_nx;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            start_ok;
  logic            sample;
  logic            health_trip;
  logic            push;
  logic            do_pop;
  logic            read_q;
  logic            err_q;

  // --------------------------------------------------------------------------
  // Capture and health decisions
  // --------------------------------------------------------------------------
  always_comb begin
    full        = (count == CW'(DEPTH));
    empty       = (count == '0);
    start_ok    = (state == S_IDLE) && start && !stop && !err_q;
    // stop takes priority over a capture in the same cycle.
    sample      = (state == S_RUN) && trng_ready && !full && !stop;
    rep_nx      = (trng_random == last_word) ? (rep_cnt + NW'(1)) : NW'(1);
    // The word that reaches the limit is dropped, not pushed.
    health_trip = sample && (rep_nx == NW'(REP_LIMIT));
    push        = sample && !health_trip;
    do_pop      = pop && !empty;
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_RST;
      end
      S_RST: begin
        if (rst_cnt == RW'(RST_CYCLES - 1)) begin
          state_nx = (cal_cnt == 32'd0) ? S_RUN : S_CALIB;
        end
      end
      S_CALIB: begin
        // cal_cnt is at least 1 on entry; leave when the last cycle is reached.
        if (cal_cnt <= 32'd1) state_nx = S_RUN;
      end
      S_RUN: begin
        if (health_trip)  state_nx = S_IDLE;
        else if (push)    state_nx = S_ACK;
      end
      S_ACK: begin
        if (!trng_ready) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
    if (stop && (state != S_IDLE)) state_nx = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // Control state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cal_cnt   <= '0;
      rst_cnt   <= '0;
      last_word <= '0;
      rep_cnt   <= '0;
      read_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      read_q <= push;

      if (start_ok) begin
        cal_cnt   <= calib_cycles;
        rst_cnt   <= '0;
        last_word <= '0;
        rep_cnt   <= '0;
      end else begin
        if (state == S_RST) rst_cnt <= rst_cnt + RW'(1);
        if ((state == S_CALIB) && (cal_cnt != 32'd0)) cal_cnt <= cal_cnt - 32'd1;
      end

      if (push) begin
        last_word <= trng_random;
        rep_cnt   <= rep_nx;
      end

      if (health_trip)  err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO: pointers and count are reset, storage is not (the head is masked to
  // zero while empty).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trng_random;
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from state or taken from registers
  // --------------------------------------------------------------------------
  always_comb begin
    trng_rst   = (state == S_IDLE) || (state == S_RST);
    trng_en    = (state == S_CALIB) || (state == S_RUN) || (state == S_ACK);
    trng_calib = (state == S_CALIB);
    trng_read  = read_q;
    busy       = (state != S_IDLE);
    health_err = err_q;
    fifo_count = count;
    pop_data   = empty ? 32'd0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// tb_trng_seq_ctrl
// Directed bench for trng_seq_ctrl with DEPTH=4, RST_CYCLES=4, REP_LIMIT=3.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_trng_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        err_clr;
  logic [31:0] calib_cycles;
  logic        trng_rst;
  logic        trng_en;
  logic        trng_calib;
  logic        trng_read;
  logic        trng_ready;
  logic [31:0] trng_random;
  logic        pop;
  logic [31:0] pop_data;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        health_err;

  int checks;
  int errors;

  trng_seq_ctrl #(
    .DEPTH      (4),
    .RST_CYCLES (4),
    .REP_LIMIT  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .err_clr      (err_clr),
    .calib_cycles (calib_cycles),
    .trng_rst     (trng_rst),
    .trng_en      (trng_en),
    .trng_calib   (trng_calib),
    .trng_read    (trng_read),
    .trng_ready   (trng_ready),
    .trng_random  (trng_random),
    .pop          (pop),
    .pop_data     (pop_data),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .health_err   (health_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word, expect it captured and acknowledged, then drop ready.
  task automatic feed(input logic [31:0] w, input logic [31:0] exp_count);
    trng_random = w;
    trng_ready  = 1'b1;
    step();
    chk("feed_read", trng_read, 1);
    chk("feed_count", fifo_count, exp_count);
    trng_ready = 1'b0;
    step();
    chk("feed_read_low", trng_read, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rst"},   trng_rst, 1);
    chk({tag, "_en"},    trng_en, 0);
    chk({tag, "_calib"}, trng_calib, 0);
    chk({tag, "_read"},  trng_read, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_data"},  pop_data, 0);
    chk({tag, "_herr"},  health_err, 0);
  endtask

  logic [31:0] full_words [5];

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    err_clr      = 1'b0;
    calib_cycles = 32'd0;
    trng_ready   = 1'b0;
    trng_random  = 32'd0;
    pop          = 1'b0;
    full_words[0] = 32'h1111_0001;
    full_words[1] = 32'h2222_0002;
    full_words[2] = 32'h3333_0003;
    full_words[3] = 32'h4444_0004;
    full_words[4] = 32'h5555_0005;

    // ---- reset ----
    step();
    step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // ---- bring-up: 1 IDLE cycle with start + 4 RST cycles + 10 CALIB ----
    calib_cycles = 32'd10;
    start = 1'b1;
    chk("start_cycle_rst", trng_rst, 1);
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_phase_rst", trng_rst, 1);
      chk("rst_phase_en", trng_en, 0);
      chk("rst_phase_busy", busy, 1);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      chk("calib_phase_calib", trng_calib, 1);
      chk("calib_phase_en", trng_en, 1);
      chk("calib_phase_rst", trng_rst, 0);
      chk("calib_phase_busy", busy, 1);
      step();
    end
    chk("run_calib", trng_calib, 0);
    chk("run_en", trng_en, 1);
    chk("run_rst", trng_rst, 0);
    chk("run_busy", busy, 1);
    chk("run_read", trng_read, 0);

    // ---- capture, ready held one extra cycle ----
    trng_random = 32'hA5A5_0001;
    trng_ready  = 1'b1;
    step();
    chk("cap_read", trng_read, 1);
    chk("cap_count", fifo_count, 1);
    chk("cap_data", pop_data, 32'hA5A5_0001);
    step();
    chk("cap_no_double_read", trng_read, 0);
    chk("cap_no_double_count", fifo_count, 1);
    trng_ready = 1'b0;
    step();
    chk("cap_back_run_read", trng_read, 0);
    chk("cap_back_run_count", fifo_count, 1);

    // ---- pop to empty, then pop on empty ----
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("pop_count", fifo_count, 0);
    chk("pop_empty_data", pop_data, 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("pop_empty_ignored", fifo_count, 0);

    // ---- full ----
    for (int i = 0; i < 4; i++) feed(full_words[i], i + 1);
    trng_random = full_words[4];
    trng_ready  = 1'b1;
    step();
    chk("full_no_read", trng_read, 0);
    chk("full_count", fifo_count, 4);
    chk("full_head", pop_data, full_words[0]);
    step();
    chk("full_no_read2", trng_read, 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("full_pop_count", fifo_count, 3);
    chk("full_pop_read", trng_read, 0);
    chk("full_pop_head", pop_data, full_words[1]);
    step();
    chk("fifth_read", trng_read, 1);
    chk("fifth_count", fifo_count, 4);
    trng_ready = 1'b0;
    step();
    for (int i = 1; i < 5; i++) begin
      chk("drain_head", pop_data, full_words[i]);
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    chk("drain_count", fifo_count, 0);

    // ---- health: third identical word trips ----
    feed(32'h1234_5678, 1);
    feed(32'h1234_5678, 2);
    trng_random = 32'h1234_5678;
    trng_ready  = 1'b1;
    step();
    trng_ready = 1'b0;
    chk("health_err", health_err, 1);
    chk("health_busy", busy, 0);
    chk("health_count", fifo_count, 2);
    chk("health_read", trng_read, 0);
    chk("health_rst", trng_rst, 1);
    calib_cycles = 32'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("health_start_ignored", busy, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", health_err, 0);

    // ---- stop/start race in CALIB ----
    start = 1'b1;
    step();
    start = 1'b0;
    chk("race_busy", busy, 1);
    repeat (4) step();
    chk("race_in_calib", trng_calib, 1);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("race_busy_low", busy, 0);
    chk("race_rst", trng_rst, 1);
    chk("race_calib_low", trng_calib, 0);
    chk("race_en_low", trng_en, 0);
    chk("race_count", fifo_count, 2);
    chk("race_head", pop_data, 32'h1234_5678);

    // ---- calib_cycles = 0: RST then directly RUN ----
    calib_cycles = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("nocal_rst", trng_rst, 1);
      chk("nocal_calib", trng_calib, 0);
      step();
    end
    chk("nocal_run_en", trng_en, 1);
    chk("nocal_run_calib", trng_calib, 0);
    chk("nocal_run_rst", trng_rst, 0);
    chk("nocal_run_busy", busy, 1);

    // ---- reset mid-RUN with 2 words queued and a word presented ----
    chk("pre_reset_count", fifo_count, 2);
    trng_random = 32'hDEAD_BEEF;
    trng_ready  = 1'b1;
    rst_n       = 1'b0;
    step();
    chk_reset_outputs("midrun");
    trng_ready = 1'b0;
    rst_n      = 1'b1;
    step();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
